// File: rtl/prbs_bert_ctrl.sv
// prbs_bert_ctrl: sequences a PRBS31 bit-error-rate test.
// The sequence is: seed the checker (LOAD), wait for a clean stretch (SYNC),
// count errors over a selectable window (RUN), then hold the results (DONE).
module prbs_bert_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  win_sel,
    input  logic        err_bit,
    output logic        gen_en,
    output logic        chk_load,
    output logic        chk_en,
    output logic        busy,
    output logic        locked,
    output logic        done,
    output logic        lock_fail,
    output logic [15:0] err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SYNC,
        ST_RUN,
        ST_DONE
    } state_t;

    // Last LOAD cycle index: 31 cycles spent shifting the seed into the checker.
    localparam logic [15:0] LOAD_LAST  = 16'd30;
    // Last SYNC cycle index before giving up on lock.
    localparam logic [15:0] SYNC_LAST  = 16'd1023;
    // Clean count already reached when the 64th consecutive clean bit arrives.
    localparam logic [6:0]  CLEAN_LAST = 7'd63;

    state_t      state_q,     state_d;
    logic [15:0] cyc_q,       cyc_d;
    logic [6:0]  clean_q,     clean_d;
    logic [1:0]  win_q,       win_d;
    logic [15:0] err_cnt_q,   err_cnt_d;
    logic        locked_q,    locked_d;
    logic        lock_fail_q, lock_fail_d;
    logic        done_q,      done_d;
    logic        gen_en_q,    gen_en_d;
    logic        chk_load_q,  chk_load_d;
    logic        chk_en_q,    chk_en_d;
    logic        busy_q,      busy_d;
    logic [15:0] win_last;
    logic        start_ok;
    logic        active_d;

    // Final RUN cycle index for the window latched at start: 2^(10+2*win) - 1.
    always_comb begin
        win_last = 16'h03FF;
        case (win_q)
            2'd0:    win_last = 16'h03FF;
            2'd1:    win_last = 16'h0FFF;
            2'd2:    win_last = 16'h3FFF;
            default: win_last = 16'hFFFF;
        endcase
    end

    // Next-state, counter and result logic; abort overrides everything else.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        clean_d     = clean_q;
        err_cnt_d   = err_cnt_q;
        locked_d    = locked_q;
        lock_fail_d = lock_fail_q;
        start_ok    = start && !abort;
        // The cycle counter runs only while a test is active.
        cyc_d       = (state_q == ST_LOAD || state_q == ST_SYNC || state_q == ST_RUN)
                      ? cyc_q + 16'd1 : 16'd0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // A new test starts from a clean slate; the window is frozen here.
                if (start_ok) begin
                    state_d     = ST_LOAD;
                    win_d       = win_sel;
                    err_cnt_d   = 16'd0;
                    locked_d    = 1'b0;
                    lock_fail_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (cyc_q == LOAD_LAST) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                clean_d = err_bit ? 7'd0 : clean_q + 7'd1;
                // A lock on the very last SYNC cycle still counts as a lock.
                if (!err_bit && clean_q == CLEAN_LAST) begin
                    locked_d = 1'b1;
                    state_d  = ST_RUN;
                end else if (cyc_q == SYNC_LAST) begin
                    lock_fail_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_RUN: begin
                if (err_bit && err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
                if (cyc_q == win_last) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort returns to IDLE, drops status flags and leaves err_cnt untouched,
        // including the error bit of the abort cycle itself.
        if (abort && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            err_cnt_d   = err_cnt_q;
            locked_d    = 1'b0;
            lock_fail_d = 1'b0;
        end

        // Both counters restart on every state change.
        if (state_d != state_q) begin
            cyc_d   = 16'd0;
            clean_d = 7'd0;
        end

        // Outputs are decoded from the next state so they line up with the state register.
        active_d   = (state_d == ST_LOAD) || (state_d == ST_SYNC) || (state_d == ST_RUN);
        gen_en_d   = active_d;
        busy_d     = active_d;
        chk_load_d = (state_d == ST_LOAD);
        chk_en_d   = (state_d == ST_SYNC) || (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 16'd0;
            clean_q     <= 7'd0;
            win_q       <= 2'd0;
            err_cnt_q   <= 16'd0;
            locked_q    <= 1'b0;
            lock_fail_q <= 1'b0;
            done_q      <= 1'b0;
            gen_en_q    <= 1'b0;
            chk_load_q  <= 1'b0;
            chk_en_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            clean_q     <= clean_d;
            win_q       <= win_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
            lock_fail_q <= lock_fail_d;
            done_q      <= done_d;
            gen_en_q    <= gen_en_d;
            chk_load_q  <= chk_load_d;
            chk_en_q    <= chk_en_d;
            busy_q      <= busy_d;
        end
    end

    assign gen_en    = gen_en_q;
    assign chk_load  = chk_load_q;
    assign chk_en    = chk_en_q;
    assign busy      = busy_q;
    assign locked    = locked_q;
    assign done      = done_q;
    assign lock_fail = lock_fail_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/prbs_bert_ctrl.md
PRBS_BERT_CTRL -- requirements
Module: prbs_bert_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a bit-error-rate test.
- abort  in  1  terminate the test in progress.
- win_sel  in  2  measurement window select.
- err_bit  in  1  per-cycle mismatch flag from the PRBS31 checker.
- gen_en  out  1  enables PRBS31 generator shifting.
- chk_load  out  1  checker shifts received data into its 31-bit register (seeding).
- chk_en  out  1  checker compare enable.
- busy  out  1  high in any state other than IDLE and DONE.
- locked  out  1  checker lock achieved for the current test.
- done  out  1  test finished; results valid.
- lock_fail  out  1  sync timeout occurred.
- err_cnt  out  16  errors counted in the RUN window.

REQ-002 All outputs SHALL be registered.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, LOAD, SYNC, RUN, DONE.
REQ-004 IDLE behaviour: gen_en, chk_load, chk_en and busy SHALL be 0; start=1 SHALL cause entry to LOAD on the next edge.
REQ-005 win_sel SHALL be captured on the accepted start edge; changes during the test SHALL be ignored.
REQ-006 Window length SHALL be 2^(10+2*win_sel) cycles: 1024, 4096, 16384 or 65536.
REQ-007 LOAD SHALL last exactly 31 cycles with chk_load=1, chk_en=0 and gen_en=1, then go to SYNC.
REQ-008 SYNC behaviour:
- gen_en=1, chk_en=1, chk_load=0.
- A consecutive-clean counter SHALL increment on err_bit=0 and clear on err_bit=1.
- On the 64th consecutive clean cycle: locked<=1 and go to RUN.
REQ-009 SYNC timeout: if 1024 cycles elapse in SYNC without lock, the block SHALL set lock_fail<=1 and go to DONE with err_cnt=0.
REQ-010 RUN behaviour:
- gen_en=1, chk_en=1.
- err_cnt SHALL increment by 1 on each cycle with err_bit=1 and saturate at 16'hFFFF (no wrap).
REQ-011 RUN SHALL last exactly the selected window (the cycle counter reaches window-1), then go to DONE; the err_bit of the final RUN cycle SHALL be counted.
REQ-012 DONE behaviour:
- done=1; gen_en, chk_en and busy = 0.
- err_cnt, locked and lock_fail SHALL be held.
REQ-013 start in DONE SHALL clear err_cnt, locked, lock_fail and done, and enter LOAD.
REQ-014 start while busy=1 SHALL be ignored.
REQ-015 abort=1 in LOAD, SYNC, RUN or DONE SHALL force IDLE on the next edge:
- done, locked and lock_fail cleared; err_cnt retained.
REQ-016 abort and start asserted in the same cycle: abort SHALL win, and the block SHALL end in IDLE.
REQ-017 The cycle counter SHALL be 16 bits and be cleared on every state transition.
REQ-018 The consecutive-clean counter SHALL be 7 bits and be cleared on every state transition.
REQ-019 err_bit SHALL be ignored in IDLE, LOAD and DONE.

Reset
REQ-020 rst_n=1 SHALL immediately (asynchronously) force IDLE and drive all outputs and internal counters to 0.
REQ-021 Reset asserted mid-test SHALL discard all results; no done pulse SHALL follow reset release.
REQ-022 After reset release, the first start SHALL be accepted on the first clk edge at which it is sampled high.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- win_sel=0, start, err_bit=0 always -> chk_load high 31 cycles; locked after 64 SYNC cycles; done after 1024 RUN cycles; err_cnt=0.
- win_sel=1, lock, then err_bit=1 on 5 RUN cycles including the last -> done, err_cnt=5.
- err_bit toggling every 10 cycles in SYNC -> no lock; after 1024 SYNC cycles lock_fail=1, done=1, err_cnt=0.
- win_sel=3, err_bit=1 throughout RUN -> err_cnt=16'hFFFF (saturated), done=1.
- abort in RUN after 3 errors -> IDLE next cycle, busy=0, done=0, err_cnt=3; a start in the same cycle as abort is not accepted.
- rst_n pulsed mid-SYNC -> all outputs 0 immediately; no done afterward; a new start runs normally.
